// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute-to-memory pipeline register of the 16-bit processor.
// Captures the ALU result, store data and memory/write-back control. Owns the
// 3-bit condition code register (bit0 Z, bit1 C, bit2 N) and drives the
// forwarding tap back to execute.
// Optional feature: define CCR_SAVE_EN to add a CCR shadow register with
// ccr_save / ccr_restore controls.
module ex_mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        in_valid,
    input  logic [2:0]  alu_control,
    input  logic [15:0] alu_out,
    input  logic        alu_carry,
    input  logic [15:0] store_data,
    input  logic [2:0]  rdst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        reg_write,
`ifdef CCR_SAVE_EN
    input  logic        ccr_save,
    input  logic        ccr_restore,
`endif
    output logic        out_valid,
    output logic [15:0] out_alu_result,
    output logic [15:0] out_store_data,
    output logic [2:0]  out_rdst,
    output logic        out_mem_read,
    output logic        out_mem_write,
    output logic        out_reg_write,
    output logic [2:0]  ccr,
    output logic        fwd_en,
    output logic [2:0]  fwd_rdst,
    output logic [15:0] fwd_value
);

    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;

    logic        valid_reg;
    logic [15:0] result_reg;
    logic [15:0] store_reg;
    logic [2:0]  rdst_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic        reg_write_reg;
    logic [2:0]  ccr_reg;
    logic [2:0]  ccr_next;
    logic        flag_z;
    logic        flag_n;

    // Flags come straight from the ALU result; carry is supplied by the ALU.
    assign flag_z = (alu_out == 16'h0000);
    assign flag_n = alu_out[15];

    // Pipeline register: reset and flush both leave a bubble, stall holds.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg     <= 1'b0;
            result_reg    <= 16'h0000;
            store_reg     <= 16'h0000;
            rdst_reg      <= 3'b000;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            reg_write_reg <= 1'b0;
        end else if (!stall) begin
            valid_reg     <= in_valid;
            result_reg    <= alu_out;
            store_reg     <= store_data;
            rdst_reg      <= rdst;
            mem_read_reg  <= mem_read & in_valid;
            mem_write_reg <= mem_write & in_valid;
            reg_write_reg <= reg_write & in_valid;
        end
    end

`ifdef CCR_SAVE_EN
    logic [2:0] shadow_reg;
    logic [2:0] shadow_next;
`endif

    // Next CCR value for a capture edge; restore overrides a flag update.
    always_comb begin
        ccr_next = ccr_reg;
        if (in_valid) begin
            case (alu_control)
                OP_ADD:  ccr_next = {flag_n, alu_carry, flag_z};
                OP_NOT:  ccr_next = {flag_n, ccr_reg[1], flag_z};
                default: ccr_next = ccr_reg;
            endcase
        end
`ifdef CCR_SAVE_EN
        if (ccr_restore) begin
            ccr_next = shadow_reg;
        end
`endif
    end

`ifdef CCR_SAVE_EN
    // Shadow takes the pre-edge CCR so save+restore together swaps the two.
    always_comb begin
        shadow_next = ccr_save ? ccr_reg : shadow_reg;
    end

    // Shadow register: cleared by reset, untouched on flush or stall edges.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_reg <= 3'b000;
        end else if (!flush && !stall) begin
            shadow_reg <= shadow_next;
        end
    end
`endif

    // CCR: a flushed instruction must not touch the flags, stall holds them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ccr_reg <= 3'b000;
        end else if (!flush && !stall) begin
            ccr_reg <= ccr_next;
        end
    end

    assign out_valid      = valid_reg;
    assign out_alu_result = result_reg;
    assign out_store_data = store_reg;
    assign out_rdst       = rdst_reg;
    assign out_mem_read   = mem_read_reg;
    assign out_mem_write  = mem_write_reg;
    assign out_reg_write  = reg_write_reg;
    assign ccr            = ccr_reg;

    // Loads are not forwardable here: their data only exists after memory.
    assign fwd_en    = valid_reg & reg_write_reg & ~mem_read_reg;
    assign fwd_rdst  = rdst_reg;
    assign fwd_value = result_reg;

endmodule
